// File: rtl/ss_seq_engine_pkg.sv
// Shared types and constants for the save-state sequencer and its CRC helper.
// The CRC trailer itself is only built when SS_SEQ_CRC_EN is defined.
package ss_seq_engine_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_SETUP   = 4'd1,
      S_RD_WAIT = 4'd2,
      S_TX      = 4'd3,
      S_RX      = 4'd4,
      S_WR      = 4'd5,
      S_WR_END  = 4'd6,
      S_CRC     = 4'd7,
      S_DONE    = 4'd8
   } ss_state_e;

   localparam logic [7:0] CRC8_POLY      = 8'h07;
   localparam logic       SS_DIR_SAVE    = 1'b0;
   localparam logic       SS_DIR_RESTORE = 1'b1;

   // One byte of CRC-8, MSB first, data folded into the top of the register.
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] din);
      logic [7:0] c;
      c = crc ^ din;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) begin
            c = {c[6:0], 1'b0} ^ CRC8_POLY;
         end else begin
            c = {c[6:0], 1'b0};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/ss_seq_engine_crc8.sv
// ss_crc8: running CRC-8 over the snapshot bytes; clr restarts it at 0x00.
// Instantiated by ss_seq_engine only when SS_SEQ_CRC_EN is defined.
module ss_crc8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] crc
);
   import ss_seq_engine_pkg::*;

   logic [7:0] crc_q, crc_d;

   // Next CRC value: clear wins over update.
   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = 8'h00;
      end else if (en) begin
         crc_d = crc8_next(crc_q, din);
      end else begin
         crc_d = crc_q;
      end
   end

   // CRC register.
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= 8'h00;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/ss_seq_engine.sv
// ss_seq_engine: initiator of the mapper save-state port; streams SAVE bytes out, RESTORE bytes in.
// Define SS_SEQ_CRC_EN to append/check a CRC-8 trailer byte (default build: plain SS_LEN bytes).
module ss_seq_engine #(
   parameter int SS_LEN  = 128,
   parameter int RD_WAIT = 2,
   parameter int WE_HOLD = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dir,
   output logic       busy,
   output logic       done,
   output logic       ss_act,
   output logic       ss_we,
   output logic [7:0] ss_addr,
   output logic [7:0] ss_wdat,
   input  logic [7:0] ss_rdat,
   output logic [7:0] tx_dat,
   output logic       tx_vld,
   input  logic       tx_rdy,
   input  logic [7:0] rx_dat,
   input  logic       rx_vld,
   output logic       rx_rdy,
   output logic       crc_err
);
   import ss_seq_engine_pkg::*;

   localparam logic [7:0]  LAST_ADDR = 8'(SS_LEN - 1);
   localparam logic [15:0] RD_LAST   = 16'(RD_WAIT - 1);
   localparam logic [15:0] WE_LAST   = 16'(WE_HOLD - 1);

   ss_state_e   state_q, state_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ss_act_q, ss_act_d;
   logic        ss_we_q, ss_we_d;
   logic [7:0]  ss_addr_q, ss_addr_d;
   logic [7:0]  ss_wdat_q, ss_wdat_d;
   logic [7:0]  tx_dat_q, tx_dat_d;
   logic        tx_vld_q, tx_vld_d;
   logic        rx_rdy_q, rx_rdy_d;
   logic        dir_q, dir_d;
   logic [15:0] cnt_q, cnt_d;

`ifdef SS_SEQ_CRC_EN
   logic        crc_err_q, crc_err_d;
   logic        crc_clr_s, crc_en_s;
   logic [7:0]  crc_din_s, crc_val_s;

   ss_crc8 u_crc (
      .clk (clk),
      .rst (rst),
      .clr (crc_clr_s),
      .en  (crc_en_s),
      .din (crc_din_s),
      .crc (crc_val_s)
   );
`endif

   // Sequencer next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ss_act_d  = ss_act_q;
      ss_we_d   = ss_we_q;
      ss_addr_d = ss_addr_q;
      ss_wdat_d = ss_wdat_q;
      tx_dat_d  = tx_dat_q;
      tx_vld_d  = tx_vld_q;
      rx_rdy_d  = rx_rdy_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
`ifdef SS_SEQ_CRC_EN
      crc_err_d = crc_err_q;
      crc_clr_s = 1'b0;
      crc_en_s  = 1'b0;
      crc_din_s = 8'h00;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SETUP;
               busy_d    = 1'b1;
               ss_act_d  = 1'b1;
               ss_addr_d = 8'h00;
               dir_d     = dir;
               cnt_d     = 16'd0;
`ifdef SS_SEQ_CRC_EN
               crc_clr_s = 1'b1;
               crc_err_d = 1'b0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            if (dir_q == SS_DIR_RESTORE) begin
               state_d  = S_RX;
               rx_rdy_d = 1'b1;
            end else begin
               state_d = S_RD_WAIT;
               cnt_d   = 16'd0;
            end
         end
         S_RD_WAIT: begin
            // Mapper readback mux needs RD_WAIT cycles after every address change.
            if (cnt_q == RD_LAST) begin
               tx_dat_d = ss_rdat;
               tx_vld_d = 1'b1;
               cnt_d    = 16'd0;
               state_d  = S_TX;
`ifdef SS_SEQ_CRC_EN
               crc_en_s  = 1'b1;
               crc_din_s = ss_rdat;
`endif
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_TX: begin
            if (tx_rdy) begin
               tx_vld_d = 1'b0;
               if (ss_addr_q == LAST_ADDR) begin
`ifdef SS_SEQ_CRC_EN
                  state_d  = S_CRC;
                  tx_vld_d = 1'b1;
                  tx_dat_d = crc_val_s;
`else
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  ss_act_d = 1'b0;
`endif
               end else begin
                  ss_addr_d = ss_addr_q + 8'd1;
                  state_d   = S_RD_WAIT;
               end
            end else begin
               state_d = S_TX;
            end
         end
         S_RX: begin
            if (rx_vld) begin
               ss_wdat_d = rx_dat;
               rx_rdy_d  = 1'b0;
               ss_we_d   = 1'b1;
               cnt_d     = 16'd0;
               state_d   = S_WR;
`ifdef SS_SEQ_CRC_EN
               crc_en_s  = 1'b1;
               crc_din_s = rx_dat;
`endif
            end else begin
               state_d = S_RX;
            end
         end
         S_WR: begin
            if (cnt_q == WE_LAST) begin
               ss_we_d = 1'b0;
               state_d = S_WR_END;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_WR_END: begin
            // Address and data stay put for this cycle so the mapper sees a clean falling strobe.
            if (ss_addr_q == LAST_ADDR) begin
`ifdef SS_SEQ_CRC_EN
               state_d  = S_CRC;
               rx_rdy_d = 1'b1;
`else
               state_d  = S_DONE;
               done_d   = 1'b1;
               ss_act_d = 1'b0;
`endif
            end else begin
               ss_addr_d = ss_addr_q + 8'd1;
               rx_rdy_d  = 1'b1;
               state_d   = S_RX;
            end
         end
`ifdef SS_SEQ_CRC_EN
         S_CRC: begin
            if (dir_q == SS_DIR_SAVE) begin
               if (tx_rdy) begin
                  tx_vld_d = 1'b0;
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  ss_act_d = 1'b0;
               end else begin
                  state_d = S_CRC;
               end
            end else begin
               if (rx_vld) begin
                  rx_rdy_d  = 1'b0;
                  crc_err_d = (rx_dat != crc_val_s);
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  ss_act_d  = 1'b0;
               end else begin
                  state_d = S_CRC;
               end
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            ss_act_d = 1'b0;
            ss_we_d  = 1'b0;
            tx_vld_d = 1'b0;
            rx_rdy_d = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ss_act_q  <= 1'b0;
         ss_we_q   <= 1'b0;
         ss_addr_q <= 8'h00;
         ss_wdat_q <= 8'h00;
         tx_dat_q  <= 8'h00;
         tx_vld_q  <= 1'b0;
         rx_rdy_q  <= 1'b0;
         dir_q     <= 1'b0;
         cnt_q     <= 16'd0;
`ifdef SS_SEQ_CRC_EN
         crc_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ss_act_q  <= ss_act_d;
         ss_we_q   <= ss_we_d;
         ss_addr_q <= ss_addr_d;
         ss_wdat_q <= ss_wdat_d;
         tx_dat_q  <= tx_dat_d;
         tx_vld_q  <= tx_vld_d;
         rx_rdy_q  <= rx_rdy_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
`ifdef SS_SEQ_CRC_EN
         crc_err_q <= crc_err_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign ss_act  = ss_act_q;
   assign ss_we   = ss_we_q;
   assign ss_addr = ss_addr_q;
   assign ss_wdat = ss_wdat_q;
   assign tx_dat  = tx_dat_q;
   assign tx_vld  = tx_vld_q;
   assign rx_rdy  = rx_rdy_q;
`ifdef SS_SEQ_CRC_EN
   assign crc_err = crc_err_q;
`else
   assign crc_err = 1'b0;
`endif

endmodule
